// File: rtl/data_qsync_pacer_pkg.sv
// Shared types and width helpers for the quasi-sync high-to-low TX pacer.
package data_qsync_pacer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Pointer width for a power-of-two FIFO depth.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Gap counter width; must hold CLK_RATIO-1.
  function automatic int gap_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/data_qsync_pacer_fifo.sv
// Small synchronous FIFO feeding the pacer; no bypass, no write when full.
module data_qsync_pacer_fifo
  import data_qsync_pacer_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = ptr_w(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_s,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    cnt
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_s) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_s) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/data_qsync_hl_tx_pacer.sv
// Paces single-cycle send_s pulses into DW_data_qsync_hl, CLK_RATIO+1 cycles apart.
// Optional sent-word counter under DATA_QSYNC_PACER_STATS_EN.
module data_qsync_hl_tx_pacer
  import data_qsync_pacer_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int CLK_RATIO = 2,
  parameter  int DEPTH     = 4,
  localparam int CW        = $clog2(DEPTH) + 1,
  localparam int GW        = gap_w(CLK_RATIO)
) (
  input  logic             clk_s,
  input  logic             rst_s,
  input  logic             init_s,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             send_s,
  output logic [WIDTH-1:0] data_s,
  output logic [CW-1:0]    fifo_cnt,
  output logic             busy
`ifdef DATA_QSYNC_PACER_STATS_EN
  , output logic [15:0]    sent_cnt
`endif
);

  state_t           state, state_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             clr, pop, full, empty;
  logic [WIDTH-1:0] head;

  assign clr = rst_s | init_s;

  data_qsync_pacer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk_s (clk_s),
    .clr   (clr),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .cnt   (fifo_cnt)
  );

  assign in_ready = !full;
  assign send_s   = (state == SEND);
  assign busy     = (state != IDLE) || !empty;

  always_ff @(posedge clk_s) begin
    if (clr) begin
      state   <= IDLE;
      gap_cnt <= '0;
      data_s  <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
      if (pop) data_s <= head;
    end
  end

  // GAP exit pops directly into SEND so a late arrival costs no IDLE cycle.
  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        state_n = SEND;
        pop     = 1'b1;
      end
      SEND: begin
        state_n = GAP;
        gap_n   = GW'(CLK_RATIO - 1);
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (!empty) begin
            state_n = SEND;
            pop     = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gap_n = gap_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef DATA_QSYNC_PACER_STATS_EN
  always_ff @(posedge clk_s) begin
    if (clr)                sent_cnt <= '0;
    else if (state == SEND) sent_cnt <= sent_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/data_qsync_hl_tx_pacer.md
# data_qsync_hl_tx_pacer

Source-domain feeder for the high-to-low quasi-synchronous data synchronizer (DW_data_qsync_hl). It accepts words over a valid/ready interface into a small FIFO. It drives the synchronizer's send_s/data_s pair with single-cycle send pulses, spaced so that every send is captured in the slower destination domain. data_s is held stable between sends. The block sits in the clk_s domain, directly upstream of the synchronizer instance.

## Interface
Parameters:
- WIDTH, 8, data word width; must equal the synchronizer width.
- CLK_RATIO, 2, clk_s cycles per clk_d cycle; range 2..16; must equal the synchronizer clk_ratio.
- DEPTH, 4, FIFO entries; power of two, range 2..16.

Ports:
- clk_s  in  1  source clock; one clock only.
- rst_s  in  1  synchronous, active-high reset.
- init_s  in  1  synchronous active-high soft clear; same effect as rst_s; rst_s has priority.
- in_valid  in  1  producer word valid.
- in_ready  out  1  FIFO can accept; equals (fifo_cnt != DEPTH).
- in_data  in  WIDTH  producer word.
- send_s  out  1  one-cycle send pulse to the synchronizer.
- data_s  out  WIDTH  word to the synchronizer; registered.
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  out  1  high when state != IDLE or fifo_cnt != 0.
- sent_cnt  out  16  words sent; present only under the macro.

## Operation
- Push: in_valid && in_ready at a rising edge writes in_data at wr_ptr. There is no write when full, even if a pop occurs in the same cycle; there is no bypass path.
- fifo_cnt per edge: +1 on push only, -1 on pop only, unchanged on push+pop. Pointers wrap modulo DEPTH.
- FSM states: IDLE, SEND, GAP.
  - IDLE -> SEND when fifo_cnt != 0. The head word is popped into data_s at the same edge.
  - SEND lasts exactly 1 cycle; send_s = (state == SEND). At exit, gap_cnt is loaded with CLK_RATIO-1.
  - GAP decrements gap_cnt each cycle. When gap_cnt == 0:
    - if the FIFO is non-empty, go to SEND and pop;
    - otherwise go to IDLE.
- data_s changes only on a pop edge and holds until the next pop.
- rst_s or init_s: FIFO emptied, pointers = 0, state = IDLE, gap_cnt = 0, data_s = 0. Pending words are discarded.

## Timing
- Reset values: send_s=0, data_s=0, in_ready=1, fifo_cnt=0, busy=0, sent_cnt=0.
- Latency: a word accepted in cycle t with the FSM in IDLE and the FIFO empty gives send_s=1 in cycle t+2, with data_s = that word in cycle t+2.
- Back-to-back backlog: send_s pulses are exactly CLK_RATIO+1 cycles apart, with CLK_RATIO+1 the minimum spacing under all conditions. Sustained throughput is 1 word per CLK_RATIO+1 cycles.
- Arrival during GAP with an empty FIFO: the send occurs at the GAP exit edge, so no spacing violation occurs and no extra IDLE cycle is spent.
- rst_s/init_s asserted in a SEND cycle: send_s=0 from the next cycle. There is no partial pulse and the word is not re-sent.
- Full FIFO: in_ready=0 in the same cycle fifo_cnt reaches DEPTH. It returns to 1 in the cycle after the pop edge.

## Configuration
- Macro DATA_QSYNC_PACER_STATS_EN.
- Defined: sent_cnt port exists. It increments by 1 at each edge ending a SEND cycle, wraps 0xFFFF->0, and is cleared by rst_s/init_s.
- Undefined: the sent_cnt port and its register are absent. All other behaviour is identical.

## Structure
- Package data_qsync_pacer_pkg holds:
  - the state enum (IDLE, SEND, GAP);
  - localparam helpers for the pointer width ($clog2(DEPTH)) and the gap_cnt width ($clog2(CLK_RATIO)).
- Sub-module data_qsync_pacer_fifo implements storage, pointers and the count, with push/pop/full/empty/cnt ports. The top level holds the FSM, the gap counter, the data_s register and the stats counter.

## Test plan
- Reset: after rst_s, check send_s=0, data_s=0, in_ready=1, fifo_cnt=0 and busy=0. Then push 0xA5 in cycle 5 -> send_s=1 and data_s=0xA5 in cycle 7 only.
- Backlog, CLK_RATIO=2, DEPTH=4: push 0x01..0x04 on consecutive cycles.
  - send_s pulses arrive 3 cycles apart with data_s 0x01..0x04 in order.
  - data_s stays stable between pulses.
- Full: push 5 words back-to-back into DEPTH=4 -> in_ready=0 once fifo_cnt=4. The 5th word is accepted only after the first pop, and no word is lost or duplicated.
- Late arrival: push one word while in GAP with the FIFO empty (CLK_RATIO=4) -> the next send_s occurs exactly 5 cycles after the previous one.
- Mid-operation clear: assert init_s in a SEND cycle with 2 words queued -> send_s=0 next cycle, fifo_cnt=0, data_s=0, and no further sends.
- Stats (macro defined): send 70000 words -> sent_cnt = 70000 mod 65536 = 4464.
